// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the 8-bit CPU control path.
//   - opcode encodings (OP_NOP .. OP_HLT)
//   - bit positions of the 16-bit control word (CTRL_HLT .. CTRL_FI)
//   - ctrl_word_t / step_t types and the sequencer run/halt state type
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef logic [15:0] ctrl_word_t;
   typedef logic [2:0]  step_t;

   typedef enum logic {
      SEQ_RUN  = 1'b0,
      SEQ_HALT = 1'b1
   } seq_state_t;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam int CTRL_HLT = 15;
   localparam int CTRL_MI  = 14;
   localparam int CTRL_RI  = 13;
   localparam int CTRL_RO  = 12;
   localparam int CTRL_IO  = 11;
   localparam int CTRL_II  = 10;
   localparam int CTRL_AI  = 9;
   localparam int CTRL_AO  = 8;
   localparam int CTRL_EO  = 7;
   localparam int CTRL_SU  = 6;
   localparam int CTRL_BI  = 5;
   localparam int CTRL_OI  = 4;
   localparam int CTRL_CE  = 3;
   localparam int CTRL_CO  = 2;
   localparam int CTRL_J   = 1;
   localparam int CTRL_FI  = 0;

   // Control word driven for the whole time the sequencer sits in HALT.
   localparam ctrl_word_t HALT_WORD = ctrl_word_t'(1) << CTRL_HLT;

endpackage

// File: rtl/microcode_rom.sv
// -----------------------------------------------------------------------------
// microcode_rom
// Purely combinational microcode table: (opcode, step, flags) -> control word
// plus a "last" marker on the final micro-step of each instruction.
// Ports:
//   opcode  in  4   current instruction opcode
//   step    in  3   current micro-step T0..T4
//   flag_c  in  1   ALU carry flag (JC)
//   flag_z  in  1   ALU zero flag (JZ)
//   ctrl    out 16  control word for this step
//   last    out 1   this step is the final one of the instruction
// Configuration macro: MICROSEQ_COND_JUMP_EN -- when undefined, JC and JZ
// decode as NOP and the flags are ignored.
// -----------------------------------------------------------------------------
module microcode_rom
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   input  step_t      step,
   input  logic       flag_c,
   input  logic       flag_z,
   output ctrl_word_t ctrl,
   output logic       last
);

`ifndef MICROSEQ_COND_JUMP_EN
   logic unused_flags;
   assign unused_flags = flag_c ^ flag_z;
`endif

   // NOTE: every output gets a default before the case so that no path
   // leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      ctrl = '0;
      last = 1'b0;
      case (step)
         3'd0: begin
            ctrl[CTRL_CO] = 1'b1;
            ctrl[CTRL_MI] = 1'b1;
         end
         3'd1: begin
            ctrl[CTRL_RO] = 1'b1;
            ctrl[CTRL_II] = 1'b1;
            ctrl[CTRL_CE] = 1'b1;
         end
         3'd2: begin
            last = 1'b1;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_MI] = 1'b1;
                  last          = 1'b0;
               end
               OP_LDI: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_AI] = 1'b1;
               end
               OP_JMP: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_J]  = 1'b1;
               end
`ifdef MICROSEQ_COND_JUMP_EN
               // Flags feed j combinationally so a change within T2 counts.
               OP_JC: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_J]  = flag_c;
               end
               OP_JZ: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_J]  = flag_z;
               end
`endif
               OP_OUT: begin
                  ctrl[CTRL_AO] = 1'b1;
                  ctrl[CTRL_OI] = 1'b1;
               end
               OP_HLT: ctrl[CTRL_HLT] = 1'b1;
               default: ;  // NOP and undefined opcodes: empty T2
            endcase
         end
         3'd3: begin
            last = 1'b1;
            case (opcode)
               OP_LDA: begin
                  ctrl[CTRL_RO] = 1'b1;
                  ctrl[CTRL_AI] = 1'b1;
               end
               OP_STA: begin
                  ctrl[CTRL_AO] = 1'b1;
                  ctrl[CTRL_RI] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl[CTRL_RO] = 1'b1;
                  ctrl[CTRL_BI] = 1'b1;
                  last          = 1'b0;
               end
               default: ;  // unreachable: force a return to T0
            endcase
         end
         default: begin
            // T4, and any out-of-range step, always ends the instruction.
            last = 1'b1;
            if (step == 3'd4 && (opcode == OP_ADD || opcode == OP_SUB)) begin
               ctrl[CTRL_EO] = 1'b1;
               ctrl[CTRL_AI] = 1'b1;
               ctrl[CTRL_FI] = 1'b1;
               ctrl[CTRL_SU] = (opcode == OP_SUB);
            end
         end
      endcase
   end

endmodule

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
// Fetch/decode/execute control unit for the 8-bit CPU. Holds the micro-step
// counter and the run/HALT state; the control word is decoded combinationally
// by microcode_rom from the current opcode, step and flags.
// Ports:
//   clk     in  1   system clock, rising edge
//   rst     in  1   asynchronous active-high reset
//   opcode  in  4   upper nibble of the instruction register
//   flag_c  in  1   registered ALU carry flag
//   flag_z  in  1   registered ALU zero flag
//   ctrl    out 16  control word {hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi}
//   step    out 3   current micro-step T0..T4
//   halted  out 1   high while halted
// Configuration macro: MICROSEQ_COND_JUMP_EN (see microcode_rom).
// -----------------------------------------------------------------------------
module microsequencer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  opcode,
   input  logic        flag_c,
   input  logic        flag_z,
   output logic [15:0] ctrl,
   output logic [2:0]  step,
   output logic        halted
);

   seq_state_t state_q, state_d;
   step_t      step_q, step_d;
   ctrl_word_t rom_ctrl;
   logic       rom_last;

   microcode_rom u_rom (
      .opcode (opcode),
      .step   (step_q),
      .flag_c (flag_c),
      .flag_z (flag_z),
      .ctrl   (rom_ctrl),
      .last   (rom_last)
   );

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEQ_RUN;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      ctrl    = rom_ctrl;
      halted  = 1'b0;
      case (state_q)
         SEQ_RUN: begin
            // The hlt bit only appears at T2 of HLT; step stays frozen at 2.
            if (rom_ctrl[CTRL_HLT]) begin
               state_d = SEQ_HALT;
            end else if (rom_last) begin
               step_d = '0;
            end else begin
               step_d = step_q + step_t'(1);
            end
         end
         SEQ_HALT: begin
            ctrl   = HALT_WORD;
            halted = 1'b1;
         end
         default: state_d = SEQ_RUN;
      endcase
   end

   assign step = step_q;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
// Self-checking bench for microsequencer: reset behaviour, a table of per-
// opcode T2 words and cycle counts, hand-written reset/halt/flag sequences,
// and random instructions compared against a per-instruction word-list model.
// -----------------------------------------------------------------------------
module tb_microsequencer;

   localparam logic [15:0] M_HLT = 16'h8000, M_MI = 16'h4000, M_RI = 16'h2000,
                           M_RO  = 16'h1000, M_IO = 16'h0800, M_II = 16'h0400,
                           M_AI  = 16'h0200, M_AO = 16'h0100, M_EO = 16'h0080,
                           M_SU  = 16'h0040, M_BI = 16'h0020, M_OI = 16'h0010,
                           M_CE  = 16'h0008, M_CO = 16'h0004, M_J  = 16'h0002,
                           M_FI  = 16'h0001;

`ifdef MICROSEQ_COND_JUMP_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  opcode;
   logic        flag_c;
   logic        flag_z;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic        halted;

   int checks = 0;
   int errors = 0;

   // Expected control words for one instruction, built from the ISA table.
   logic [15:0] exp_words [5];
   int          exp_len;

   typedef struct {
      logic [3:0]  op;
      logic        fc;
      logic        fz;
      logic [15:0] t2;
      int          cycles;
   } vec_t;

   vec_t vecs [12];

   microsequencer dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .flag_c (flag_c),
      .flag_z (flag_z),
      .ctrl   (ctrl),
      .step   (step),
      .halted (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model: the instruction's control words as a plain list.
   task automatic build_expect(input logic [3:0] op, input logic fc, input logic fz);
      logic [15:0] w [$];
      w = {M_CO | M_MI, M_RO | M_II | M_CE};
      case (op)
         4'h1: w = {w, M_IO | M_MI, M_RO | M_AI};
         4'h2: w = {w, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI};
         4'h3: w = {w, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI | M_SU};
         4'h4: w = {w, M_IO | M_MI, M_AO | M_RI};
         4'h5: w.push_back(M_IO | M_AI);
         4'h6: w.push_back(M_IO | M_J);
         4'h7: w.push_back(COND_EN ? (M_IO | (fc ? M_J : 16'h0)) : 16'h0);
         4'h8: w.push_back(COND_EN ? (M_IO | (fz ? M_J : 16'h0)) : 16'h0);
         4'hE: w.push_back(M_AO | M_OI);
         4'hF: w.push_back(M_HLT);
         default: w.push_back(16'h0);
      endcase
      exp_len = w.size();
      for (int i = 0; i < 5; i++) exp_words[i] = (i < exp_len) ? w[i] : 16'h0;
   endtask

   // Runs one whole instruction from T0, comparing every step against the model.
   task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz);
      opcode = op;
      flag_c = fc;
      flag_z = fz;
      build_expect(op, fc, fz);
      for (int k = 0; k < exp_len; k++) begin
         check($sformatf("op%0h step T%0d", op, k), {13'd0, step}, 16'(k));
         check($sformatf("op%0h ctrl T%0d", op, k), ctrl, exp_words[k]);
         if ((ctrl & (M_RI | M_RO)) == (M_RI | M_RO))
            check($sformatf("op%0h ri/ro clash T%0d", op, k), ctrl & (M_RI | M_RO), 16'h0);
         tick();
      end
      check($sformatf("op%0h return to T0", op), {13'd0, step}, 16'h0);
   endtask

   initial begin
      int cycles;

      vecs[0]  = '{4'h0, 1'b0, 1'b0, 16'h0000, 3};
      vecs[1]  = '{4'h1, 1'b0, 1'b0, 16'h4800, 4};
      vecs[2]  = '{4'h2, 1'b1, 1'b0, 16'h4800, 5};
      vecs[3]  = '{4'h3, 1'b0, 1'b1, 16'h4800, 5};
      vecs[4]  = '{4'h4, 1'b0, 1'b0, 16'h4800, 4};
      vecs[5]  = '{4'h5, 1'b0, 1'b0, 16'h0A00, 3};
      vecs[6]  = '{4'h6, 1'b0, 1'b0, 16'h0802, 3};
      vecs[7]  = '{4'h7, 1'b0, 1'b1, COND_EN ? 16'h0800 : 16'h0000, 3};
      vecs[8]  = '{4'h7, 1'b1, 1'b0, COND_EN ? 16'h0802 : 16'h0000, 3};
      vecs[9]  = '{4'h8, 1'b1, 1'b1, COND_EN ? 16'h0802 : 16'h0000, 3};
      vecs[10] = '{4'hE, 1'b1, 1'b1, 16'h0110, 3};
      vecs[11] = '{4'hA, 1'b1, 1'b1, 16'h0000, 3};

      rst    = 1'b1;
      opcode = 4'h0;
      flag_c = 1'b0;
      flag_z = 1'b0;
      #1;
      check("reset ctrl", ctrl, 16'h4004);
      check("reset step", {13'd0, step}, 16'h0);
      check("reset halted", {15'd0, halted}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("first edge step", {13'd0, step}, 16'h1);
      check("first edge ctrl", ctrl, 16'h1408);
      do_reset();

      // Table: T2 word and total cycle count per opcode/flag combination.
      foreach (vecs[i]) begin
         opcode = vecs[i].op;
         flag_c = vecs[i].fc;
         flag_z = vecs[i].fz;
         tick();
         tick();
         check($sformatf("vec%0d T2 ctrl", i), ctrl, vecs[i].t2);
         cycles = 2;
         do begin
            tick();
            cycles++;
         end while (step != 3'd0 && cycles < 8);
         check($sformatf("vec%0d cycles", i), 16'(cycles), 16'(vecs[i].cycles));
      end

      // Full step-by-step sequences for the multi-step opcodes.
      run_instr(4'h1, 1'b0, 1'b0);
      run_instr(4'h3, 1'b1, 1'b0);

      // Flag change inside T2 of JC is seen in the same cycle.
      opcode = 4'h7;
      flag_c = 1'b0;
      tick();
      tick();
      check("jc T2 flag low", ctrl, COND_EN ? 16'h0800 : 16'h0000);
      flag_c = 1'b1;
      #1;
      check("jc T2 flag rises", ctrl, COND_EN ? 16'h0802 : 16'h0000);
      tick();
      check("jc return", {13'd0, step}, 16'h0);

      // Asynchronous reset in the middle of T3 of ADD.
      opcode = 4'h2;
      tick();
      tick();
      tick();
      check("add mid T3 step", {13'd0, step}, 16'h3);
      rst = 1'b1;
      #1;
      check("async reset ctrl", ctrl, 16'h4004);
      check("async reset step", {13'd0, step}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("post reset step", {13'd0, step}, 16'h1);
      check("post reset ctrl", ctrl, 16'h1408);
      do_reset();

      // HLT: enters HALT after T2 and holds until reset.
      opcode = 4'hF;
      tick();
      tick();
      check("hlt T2 ctrl", ctrl, 16'h8000);
      check("hlt T2 halted", {15'd0, halted}, 16'h0);
      tick();
      for (int i = 0; i < 10; i++) begin
         check($sformatf("halt%0d halted", i), {15'd0, halted}, 16'h1);
         check($sformatf("halt%0d ctrl", i), ctrl, 16'h8000);
         check($sformatf("halt%0d step", i), {13'd0, step}, 16'h2);
         opcode = 4'($urandom_range(0, 15));
         tick();
      end
      rst = 1'b1;
      #1;
      check("halt reset ctrl", ctrl, 16'h4004);
      check("halt reset halted", {15'd0, halted}, 16'h0);
      check("halt reset step", {13'd0, step}, 16'h0);
      @(negedge clk);
      rst = 1'b0;

      // Random instruction stream against the model (HLT excluded).
      for (int n = 0; n < 40; n++) begin
         run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
